instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch-side initiator for instruction_memory: owns the program counter, drives the memory address and captures the returned word into the IF/ID pipeline register.
- Honours the memory's load phase (start), pipeline stalls, EX-stage branch redirects, a halt word and misaligned/out-of-range targets.
- Sits between instruction_memory (combinational read) and the decode stage.

Parameters:
RESET_PC, 32'd0, PC value after reset and after every load phase
ADDR_LIMIT, 32'd256, instruction memory size in bytes; a power of two and a multiple of 4
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  memory load phase in progress; same meaning as instruction_memory startin
stall  input  1  hold PC and IF/ID (hazard unit)
branch_taken  input  1  redirect request from EX
branch_target  input  32  redirect byte address
imem_address  output  32  address to instruction_memory, equals PC (combinational)
imem_instruction  input  32  word returned combinationally by instruction_memory
if_id_pc  output  32  PC of the captured instruction
if_id_instruction  output  32  captured instruction
if_id_valid  output  1  IF/ID holds a valid instruction
halted  output  1  state is HALTED
fault  output  1  state is FAULT

Behaviour:
- Reset (rst_n low, asynchronous): PC=RESET_PC, state=LOAD, if_id_pc=0, if_id_instruction=0, if_id_valid=0, halted=0, fault=0.
- States: LOAD, RUN, HALTED, FAULT. halted and fault are decoded from the state register.
- Priority at each rising edge: start > branch_taken > stall > normal fetch.
- start=1 in any state: next state LOAD, PC=RESET_PC, if_id_valid=0. IF/ID data is held.
- LOAD with start=0: next state RUN. No fetch is captured on this edge.
- RUN, normal fetch (no stall, no branch):
  - if_id_instruction<=imem_instruction, if_id_pc<=PC, if_id_valid<=1.
  - PC<=(PC+4) mod ADDR_LIMIT; PC=ADDR_LIMIT-4 wraps to 0.
  - Fetch latency: the word at address A appears in IF/ID one edge after PC=A.
- RUN, stall=1: PC and all IF/ID outputs hold.
- branch_taken=1 in RUN or HALTED, start=0:
  - Redirect wins over stall. if_id_valid<=0 to flush the wrong-path instruction.
  - branch_target[1:0]!=0 or branch_target>=ADDR_LIMIT: next state FAULT, PC holds.
  - Otherwise PC<=branch_target and next state RUN; a redirect leaves HALTED because the halt was wrong-path.
- Halt: a normal fetch with imem_instruction==HALT_WORD captures the word with if_id_valid=1 and moves to HALTED; PC holds.
  - In HALTED with no branch: if_id_valid<=0 at the next edge; PC holds. Exit only by branch_taken or start.
  - A stall on the halt-fetch edge takes priority, so the halt word is not captured until the stall releases.
- FAULT: if_id_valid=0, PC holds, branch_taken and stall are ignored; start is the only exit.
- The PC is always word-aligned, so imem_address[1:0]=0 at all times.

Optional Feature:
IFU_PERF_CNT_EN:
- Defined: adds output fetch_count[31:0]. Reset to 0 and cleared while start=1. Increments on every edge where if_id_valid is loaded with 1. Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start=1 for 20 time units (2 cycles), then 0 -> imem_address=0 throughout; if_id_valid=0 during LOAD and on the first RUN edge; IF/ID then shows (pc,instr) for pc=0,4,8,...,44 on consecutive edges.
- stall=1 for 3 cycles while PC=12 -> imem_address stays 12; IF/ID holds the pc=8 word; fetch resumes with pc=12.
- branch_taken=1 with target 32'd40, together with stall=1 -> next PC=40; if_id_valid=0 for one cycle, then the pc=40 word is captured.
- Word at 20 equals 32'hFFFF_FFFF -> captured with valid=1; halted=1; PC stays 20; valid=0 after one cycle. A later branch to 4 resumes fetch at 4 with halted=0.
- Branch target 32'd6, then target 32'd256 after a restart -> fault=1, if_id_valid=0, further branches ignored; start pulse returns to LOAD with PC=0 and fault=0.
- Branch to 252 -> PC goes 252, then 0; the IF/ID pc sequence is 252, 0. With IFU_PERF_CNT_EN, fetch_count after the 12-word sequential run = 12.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, addresses the
// combinational instruction memory and captures the returned word into the
// IF/ID pipeline register. It handles the memory load phase, stalls, EX-stage
// redirects, a halt encoding and illegal redirect targets.
//
// Optional feature: define IFU_PERF_CNT_EN to add the fetch_count output,
// which counts every instruction captured into IF/ID as valid.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] ADDR_LIMIT = 32'd256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] r_ifIdPc;
  logic [31:0] r_ifIdInstruction;
  logic        r_ifIdValid;
  logic        w_validNext;
  logic        w_capture;
  logic        w_targetBad;
  logic        w_isHalt;
  logic [31:0] w_pcInc;

  // A redirect is illegal if it is not word aligned or lies past the memory.
  assign w_targetBad = (branch_target[1:0] != 2'b00) || (branch_target >= ADDR_LIMIT);
  assign w_isHalt    = (imem_instruction == HALT_WORD);
  // ADDR_LIMIT is a power of two, so masking gives the wrap to address 0.
  assign w_pcInc     = (r_pc + 32'd4) & (ADDR_LIMIT - 32'd1);

  assign imem_address      = r_pc;
  assign if_id_pc          = r_ifIdPc;
  assign if_id_instruction = r_ifIdInstruction;
  assign if_id_valid       = r_ifIdValid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: start beats redirect, redirect beats stall.
  always_comb begin
    w_stateNext = r_state;
    if (start) begin
      w_stateNext = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          w_stateNext = S_RUN;
        end
        S_RUN: begin
          if (branch_taken) begin
            w_stateNext = w_targetBad ? S_FAULT : S_RUN;
          end else if (!stall && w_isHalt) begin
            w_stateNext = S_HALTED;
          end
        end
        S_HALTED: begin
          if (branch_taken) begin
            w_stateNext = w_targetBad ? S_FAULT : S_RUN;
          end
        end
        S_FAULT: begin
          w_stateNext = S_FAULT;
        end
        default: begin
          w_stateNext = S_LOAD;
        end
      endcase
    end
  end

  // Output decode of the state register.
  always_comb begin
    halted = (r_state == S_HALTED);
    fault  = (r_state == S_FAULT);
  end

  // Datapath control: next PC, whether IF/ID captures, and the next valid bit.
  always_comb begin
    w_pcNext    = r_pc;
    w_capture   = 1'b0;
    w_validNext = r_ifIdValid;
    if (start) begin
      w_pcNext    = RESET_PC;
      w_validNext = 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          w_validNext = 1'b0;
        end
        S_RUN, S_HALTED: begin
          if (branch_taken) begin
            w_validNext = 1'b0;
            if (!w_targetBad) begin
              w_pcNext = branch_target;
            end
          end else if (r_state == S_HALTED) begin
            w_validNext = 1'b0;
          end else if (!stall) begin
            w_capture   = 1'b1;
            w_validNext = 1'b1;
            if (!w_isHalt) begin
              w_pcNext = w_pcInc;
            end
          end
        end
        S_FAULT: begin
          w_validNext = 1'b0;
        end
        default: begin
          w_validNext = 1'b0;
        end
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pcNext;
    end
  end

  // IF/ID pipeline register; data only moves on a capture, valid every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifIdPc          <= 32'd0;
      r_ifIdInstruction <= 32'd0;
      r_ifIdValid       <= 1'b0;
    end else begin
      r_ifIdValid <= w_validNext;
      if (w_capture) begin
        r_ifIdPc          <= r_pc;
        r_ifIdInstruction <= imem_instruction;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetchCount;

  assign fetch_count = r_fetchCount;

  // Fetch counter: cleared during the load phase, bumped on each valid capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchCount <= 32'd0;
    end else if (start) begin
      r_fetchCount <= 32'd0;
    end else if (w_capture) begin
      r_fetchCount <= r_fetchCount + 32'd1;
    end
  end
`endif

endmodule
